// File: rtl/sha256_serial_sub_pkg.sv
// Shared constants and state encoding for the digit-serial SHA-256 word subtractor.
package sha256_serial_sub_pkg;

    localparam int WIDTH      = 32;
    localparam int DIGIT_W    = 4;
    localparam int NUM_DIGITS = WIDTH / DIGIT_W;
    localparam int CNT_W      = $clog2(NUM_DIGITS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sha256_digit_sub.sv
// Combinational DIGIT_W-bit ripple-borrow subtract cell: {bout, d} = a - b - bin.
module sha256_digit_sub
    import sha256_serial_sub_pkg::*;
(
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               bin,
    output logic [DIGIT_W-1:0] d,
    output logic               bout
);

    logic w_br;

    // Ripple a full-subtractor chain from the LSB upward.
    always_comb begin
        d    = '0;
        w_br = bin;
        for (int i = 0; i < DIGIT_W; i++) begin
            d[i] = a[i] ^ b[i] ^ w_br;
            w_br = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & w_br);
        end
        bout = w_br;
    end

endmodule

// File: rtl/sha256_serial_sub.sv
// Digit-serial (minuend - subtrahend) mod 2^32 with valid/ready on both sides.
// Optional final-borrow output enabled by defining SHA256_SUB_BORROW_EN.
module sha256_serial_sub
    import sha256_serial_sub_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] minuend,
    input  logic [WIDTH-1:0] subtrahend,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff
`ifdef SHA256_SUB_BORROW_EN
    ,
    output logic             borrow_out
`endif
);

    localparam logic [CNT_W-1:0] LAST_DIGIT = CNT_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

    state_t             r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_diff;
    logic               r_borrow;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIGIT_W-1:0] w_d;
    logic               w_bout;
`ifdef SHA256_SUB_BORROW_EN
    logic               r_borrow_out;
`endif

    sha256_digit_sub u_cell (
        .a    (r_a[DIGIT_W-1:0]),
        .b    (r_b[DIGIT_W-1:0]),
        .bin  (r_borrow),
        .d    (w_d),
        .bout (w_bout)
    );

    // Control FSM plus operand/result shift registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_a         <= '0;
            r_b         <= '0;
            r_diff      <= '0;
            r_borrow    <= 1'b0;
            r_cnt       <= '0;
`ifdef SHA256_SUB_BORROW_EN
            r_borrow_out <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    if (in_valid && r_in_ready) begin
                        r_a        <= minuend;
                        r_b        <= subtrahend;
                        r_borrow   <= 1'b0;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Result digits enter at the MSB so the first digit ends up at bit 0.
                    r_diff   <= {w_d, r_diff[WIDTH-1:DIGIT_W]};
                    r_a      <= r_a >> DIGIT_W;
                    r_b      <= r_b >> DIGIT_W;
                    r_borrow <= w_bout;
                    r_cnt    <= r_cnt + CNT_ONE;
                    if (r_cnt == LAST_DIGIT) begin
                        r_state     <= ST_DONE;
                        r_out_valid <= 1'b1;
`ifdef SHA256_SUB_BORROW_EN
                        r_borrow_out <= w_bout;
`endif
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state     <= ST_IDLE;
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign diff      = r_diff;
`ifdef SHA256_SUB_BORROW_EN
    assign borrow_out = r_borrow_out;
`endif

endmodule
